smm_ctrl: RTL
=============

SMM_CTRL -- requirements
Module: smm_ctrl

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 32: element width in bits.
REQ-002 The block SHALL have parameter BUSWIDTH, default DATAWIDTH*16: width of a packed 4x4 matrix.
REQ-003 The block SHALL have parameter LATENCY, default 8, legal range 1-255: datapath cycles from the sampled load to a valid result.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port req_valid, input, 1 bit: a job is offered.
REQ-007 The block SHALL have port req_ready, output, 1 bit: the controller accepts a job.
REQ-008 The block SHALL have ports req_a and req_b, input, BUSWIDTH bits each: operand matrices.
REQ-009 The block SHALL have port req_mode, input, 1 bit: the job's datapath select value (0 = full, 1 = reduced).
REQ-010 The block SHALL have ports dp_load and dp_sel, output, 1 bit each: datapath load strobe and select.
REQ-011 The block SHALL have ports dp_a and dp_b, output, BUSWIDTH bits each: datapath operands.
REQ-012 The block SHALL have port dp_c, input, BUSWIDTH bits: datapath result.
REQ-013 The block SHALL have port rsp_valid, output, 1 bit: the result is available.
REQ-014 The block SHALL have port rsp_ready, input, 1 bit: the consumer takes the result.
REQ-015 The block SHALL have port rsp_c, output, BUSWIDTH bits: the captured result.
REQ-016 The block SHALL have port busy, output, 1 bit: the FSM is not IDLE.
REQ-017 The block SHALL have port job_count, output, 16 bits: count of completed jobs.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, LOAD, WAIT and DONE.
REQ-019 The block SHALL drive req_ready=1 only in IDLE; a job is accepted at a rising edge where req_valid and req_ready are both 1.
REQ-020 On acceptance, the block SHALL register req_a, req_b and req_mode into dp_a, dp_b and dp_sel, and move IDLE->LOAD.
REQ-021 dp_a, dp_b and dp_sel SHALL then hold constant until the next acceptance.
REQ-022 In LOAD, dp_load SHALL be 1 for exactly one cycle; dp_load SHALL be 0 in every other state.
REQ-023 LOAD SHALL always go to WAIT, with an 8-bit wait counter cleared to 0.
REQ-024 In WAIT, the counter SHALL increment every cycle.
REQ-025 When the counter equals LATENCY-1, dp_c SHALL be captured into rsp_c and the FSM SHALL go to DONE.
REQ-026 rsp_valid SHALL rise exactly LATENCY+1 edges after the acceptance edge.
REQ-027 In DONE, rsp_valid=1 and rsp_c SHALL hold stable until an edge where rsp_ready=1; at that edge the FSM SHALL go to IDLE.
REQ-028 rsp_ready asserted outside DONE SHALL be ignored.
REQ-029 A req_valid held during DONE with rsp_ready=1 SHALL NOT be accepted in that cycle; it is accepted at the following edge, with a minimum of one IDLE cycle between jobs.
REQ-030 A change of req_mode, req_a or req_b after acceptance SHALL NOT affect the job in flight.
REQ-031 busy SHALL be 1 in LOAD, WAIT and DONE, and 0 in IDLE.

Reset
REQ-032 When rst=0, regardless of clk, the block SHALL force: state IDLE, dp_load=0, dp_sel=0, dp_a=0, dp_b=0, rsp_valid=0, rsp_c=0, wait counter=0, job_count=0.
REQ-033 After reset, req_ready SHALL be 1 and busy 0.
REQ-034 Reset during LOAD, WAIT or DONE SHALL abandon the job with no response.
REQ-035 The first rising edge after rst returns to 1 SHALL be able to accept a job.

Configuration
REQ-036 The block SHALL have macro SMM_CTRL_PERF_EN.
REQ-037 With SMM_CTRL_PERF_EN defined, job_count SHALL increment by 1 on each rsp handshake (rsp_valid and rsp_ready both 1) and wrap from 0xFFFF to 0x0000.
REQ-038 Without SMM_CTRL_PERF_EN, job_count SHALL be tied to 0 and contain no counter logic; all other behaviour SHALL be identical.

Verification
REQ-039 Bench SHALL cover: LATENCY=8, A=identity, B=all 0x00000002, mode=0, rsp_ready=1 -> dp_load high one cycle after acceptance, rsp_valid at edge 9 after acceptance, rsp_c all 0x00000002, job_count=1.
REQ-040 Bench SHALL cover: mode=1 with req_mode toggled to 0 one cycle after acceptance -> dp_sel stays 1 until DONE.
REQ-041 Bench SHALL cover: rsp_ready held 0 for 20 cycles -> rsp_valid and rsp_c stable, req_ready=0 throughout; release -> IDLE next edge.
REQ-042 Bench SHALL cover: back-to-back req_valid=1 with rsp_ready=1 -> jobs accepted every LATENCY+3 cycles (LATENCY=8: every 11), none lost.
REQ-043 Bench SHALL cover: rst=0 asserted mid-WAIT (counter=4) -> outputs zero asynchronously, rsp_valid never asserts for that job, next job completes normally.
REQ-044 Bench SHALL cover: SMM_CTRL_PERF_EN defined and job_count preset to 0xFFFF via 65535 jobs, or forced -> one more job gives 0x0000; macro undefined -> job_count stays 0.

Source files
------------

// File: rtl/smm_ctrl_if.sv
// ============================================================================
// Module  : smm_ctrl_if
// Purpose : Job request, datapath and response bundle for smm_ctrl.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface smm_ctrl_if #(
  parameter int BUSWIDTH = 512
);
  logic                req_valid;
  logic                req_ready;
  logic [BUSWIDTH-1:0] req_a;
  logic [BUSWIDTH-1:0] req_b;
  logic                req_mode;
  logic                dp_load;
  logic                dp_sel;
  logic [BUSWIDTH-1:0] dp_a;
  logic [BUSWIDTH-1:0] dp_b;
  logic [BUSWIDTH-1:0] dp_c;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [BUSWIDTH-1:0] rsp_c;
  logic                busy;
  logic [15:0]         job_count;

  modport master (
    output req_valid, req_a, req_b, req_mode, dp_c, rsp_ready,
    input  req_ready, dp_load, dp_sel, dp_a, dp_b, rsp_valid, rsp_c, busy, job_count
  );

  modport slave (
    input  req_valid, req_a, req_b, req_mode, dp_c, rsp_ready,
    output req_ready, dp_load, dp_sel, dp_a, dp_b, rsp_valid, rsp_c, busy, job_count
  );
endinterface

`default_nettype wire

// File: rtl/smm_ctrl.sv
// ============================================================================
// Module  : smm_ctrl
// Purpose : IDLE/LOAD/WAIT/DONE sequencer for a fixed-latency 4x4 matrix
//           datapath. Optional job counter enabled by SMM_CTRL_PERF_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module smm_ctrl #(
  parameter int DATAWIDTH = 32,
  parameter int BUSWIDTH  = DATAWIDTH * 16,
  parameter int LATENCY   = 8
) (
  input  wire logic  clk,
  input  wire logic  rst,
  smm_ctrl_if.slave  bus
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_load = 2'd1;
  localparam logic [1:0] c_wait = 2'd2;
  localparam logic [1:0] c_done = 2'd3;
  localparam logic [7:0] c_last = 8'(LATENCY - 1);

  if (BUSWIDTH != DATAWIDTH * 16) begin : g_bad_width
    $error("smm_ctrl: BUSWIDTH must equal 16*DATAWIDTH");
  end
  if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
    $error("smm_ctrl: LATENCY must be in 1..255");
  end

  logic [1:0]          r_state;
  logic [1:0]          w_next_state;
  logic [7:0]          r_wait_cnt;
  logic                r_dp_sel;
  logic [BUSWIDTH-1:0] r_dp_a;
  logic [BUSWIDTH-1:0] r_dp_b;
  logic [BUSWIDTH-1:0] r_rsp_c;
  logic                w_accept;
  logic                w_wait_done;
  logic                w_rsp_hs;

  assign w_accept    = (r_state == c_idle) && bus.req_valid;
  assign w_wait_done = (r_state == c_wait) && (r_wait_cnt == c_last);
  assign w_rsp_hs    = (r_state == c_done) && bus.rsp_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle: if (bus.req_valid) w_next_state = c_load;
      c_load: w_next_state = c_wait;
      c_wait: if (w_wait_done) w_next_state = c_done;
      c_done: if (bus.rsp_ready) w_next_state = c_idle;
      default: w_next_state = c_idle;
    endcase
  end

  always_comb begin
    bus.req_ready = 1'b0;
    bus.dp_load   = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.busy      = 1'b1;
    case (r_state)
      c_idle: begin
        bus.req_ready = 1'b1;
        bus.busy      = 1'b0;
      end
      c_load: bus.dp_load   = 1'b1;
      c_done: bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Counter restarts in LOAD so every job sees the full LATENCY window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait_cnt <= 8'd0;
    end else if (r_state == c_load) begin
      r_wait_cnt <= 8'd0;
    end else if (r_state == c_wait) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dp_sel <= 1'b0;
      r_dp_a   <= '0;
      r_dp_b   <= '0;
      r_rsp_c  <= '0;
    end else begin
      if (w_accept) begin
        r_dp_sel <= bus.req_mode;
        r_dp_a   <= bus.req_a;
        r_dp_b   <= bus.req_b;
      end
      if (w_wait_done) begin
        r_rsp_c <= bus.dp_c;
      end
    end
  end

  assign bus.dp_sel = r_dp_sel;
  assign bus.dp_a   = r_dp_a;
  assign bus.dp_b   = r_dp_b;
  assign bus.rsp_c  = r_rsp_c;

`ifdef SMM_CTRL_PERF_EN
  logic [15:0] r_job_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_job_count <= 16'd0;
    end else if (w_rsp_hs) begin
      r_job_count <= r_job_count + 16'd1;
    end
  end

  assign bus.job_count = r_job_count;
`else
  logic w_unused_hs;
  assign w_unused_hs   = w_rsp_hs;
  assign bus.job_count = 16'd0;
`endif

endmodule

`default_nettype wire
